// File: rtl/pc_next_unit.sv
// Program-counter stage for the fetch front end: holds the architectural PC,
// picks trap / redirect / sequential next-PC, flags misaligned redirect targets,
// counts accepted fetches and presents the PC to fetch over valid/ready.
module pc_next_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter bit               C_EXT        = 1'b0,
  parameter int               CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_inc,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [XLEN-1:0]  misaligned_addr,
  output logic [CNT_W-1:0] fetch_count
);

  // Instruction granule: 2 bytes with compressed instructions, 4 otherwise.
  localparam int              INC        = C_EXT ? 2 : 4;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             misaligned_q, misaligned_d;
  logic [XLEN-1:0]  misaligned_addr_q, misaligned_addr_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic accept;
  logic target_misaligned;

  assign accept            = pc_valid_q & fetch_ready & ~stall;
  assign target_misaligned = |(redirect_target & ALIGN_MASK);

  // Sequential successor; the add simply drops the carry out, giving the wrap.
  assign pc_plus_inc = pc_q + XLEN'(INC);

  // Next-state, next-PC and bookkeeping, in priority order trap > redirect > accept.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d           = state_q;
    pc_d              = pc_q;
    misaligned_d      = 1'b0;
    misaligned_addr_d = misaligned_addr_q;
    fetch_count_d     = fetch_count_q;

    // The issued PC counts even when a redirect replaces it in the same cycle.
    if (accept) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end

    if (state_q == BOOT) begin
      state_d = RUN;
    end

    if (trap_valid) begin
      pc_d    = trap_vector & ~ALIGN_MASK;
      state_d = RUN;
    end else if (redirect_valid && state_q == RUN && !target_misaligned) begin
      pc_d = redirect_target;
    end else if (redirect_valid && state_q == RUN) begin
      misaligned_d      = 1'b1;
      misaligned_addr_d = redirect_target;
      state_d           = HALT;
    end else if (accept) begin
      pc_d = pc_plus_inc;
    end

    pc_valid_d = (state_d == RUN);
  end

  // State and output registers; reset clears everything including a pending pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= BOOT;
      pc_q              <= RESET_VECTOR;
      pc_valid_q        <= 1'b0;
      misaligned_q      <= 1'b0;
      misaligned_addr_q <= '0;
      fetch_count_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q           <= state_d;
      pc_q              <= pc_d;
      pc_valid_q        <= pc_valid_d;
      misaligned_q      <= misaligned_d;
      misaligned_addr_q <= misaligned_addr_d;
      fetch_count_q     <= fetch_count_d;
    end
  end

  assign pc              = pc_q;
  assign pc_valid        = pc_valid_q;
  assign misaligned      = misaligned_q;
  assign misaligned_addr = misaligned_addr_q;
  assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: one instance with 4-byte instructions and a 32-bit
// counter, one with compressed instructions, a 4-bit counter and a non-zero
// reset vector. Expected fetch PCs are queued by the stimulus and popped by a
// monitor on every accepted fetch; state outputs are compared directly.
module tb_pc_next_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: C_EXT=0, CNT_W=32, RESET_VECTOR=0
  logic        a_reset, a_stall, a_fr, a_rv, a_tv;
  logic [31:0] a_rt, a_tvec;
  logic [31:0] a_pc, a_ppi, a_maddr, a_cnt;
  logic        a_pv, a_mis;

  // Instance B: C_EXT=1, CNT_W=4, RESET_VECTOR=0x100
  logic        b_reset, b_stall, b_fr, b_rv, b_tv;
  logic [31:0] b_rt, b_tvec;
  logic [31:0] b_pc, b_ppi, b_maddr;
  logic [3:0]  b_cnt;
  logic        b_pv, b_mis;

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0), .CNT_W(32)) dut_a (
    .clk(clk), .reset(a_reset), .stall(a_stall), .fetch_ready(a_fr),
    .redirect_valid(a_rv), .redirect_target(a_rt),
    .trap_valid(a_tv), .trap_vector(a_tvec),
    .pc(a_pc), .pc_plus_inc(a_ppi), .pc_valid(a_pv),
    .misaligned(a_mis), .misaligned_addr(a_maddr), .fetch_count(a_cnt)
  );

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .C_EXT(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .stall(b_stall), .fetch_ready(b_fr),
    .redirect_valid(b_rv), .redirect_target(b_rt),
    .trap_valid(b_tv), .trap_vector(b_tvec),
    .pc(b_pc), .pc_plus_inc(b_ppi), .pc_valid(b_pv),
    .misaligned(b_mis), .misaligned_addr(b_maddr), .fetch_count(b_cnt)
  );

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are settled then.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted fetch must match the next queued PC.
  always @(negedge clk) begin
    if (a_pv && a_fr && !a_stall) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++;
        $display("FAIL a_fetch_unexpected: got pc 0x%0h expected no fetch", a_pc);
      end else begin
        logic [31:0] e;
        e = exp_a_q.pop_front();
        if (a_pc !== e) begin
          errors++;
          $display("FAIL a_fetch_pc: got 0x%0h expected 0x%0h", a_pc, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_pv && b_fr && !b_stall) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL b_fetch_unexpected: got pc 0x%0h expected no fetch", b_pc);
      end else begin
        logic [31:0] e;
        e = exp_b_q.pop_front();
        if (b_pc !== e) begin
          errors++;
          $display("FAIL b_fetch_pc: got 0x%0h expected 0x%0h", b_pc, e);
        end
      end
    end
  end

  // Run-time bound so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc;

    a_reset = 1'b1; a_stall = 1'b0; a_fr = 1'b0; a_rv = 1'b0; a_rt = '0; a_tv = 1'b0; a_tvec = '0;
    b_reset = 1'b1; b_stall = 1'b0; b_fr = 1'b0; b_rv = 1'b0; b_rt = '0; b_tv = 1'b0; b_tvec = '0;
    repeat (3) tick();

    // ---------------- Instance A ----------------
    check("a_rst_pc", a_pc, 32'h0);
    check("a_rst_pv", a_pv, 1'b0);
    check("a_rst_mis", a_mis, 1'b0);
    check("a_rst_maddr", a_maddr, 32'h0);
    check("a_rst_cnt", a_cnt, 32'h0);

    // Release: one BOOT cycle without a valid PC, then sequential fetches.
    a_reset = 1'b0;
    a_fr    = 1'b1;
    check("a_boot_pv", a_pv, 1'b0);
    tick();
    check("a_run_pv", a_pv, 1'b1);
    exp_pc = 32'h0;
    repeat (4) begin
      exp_a_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'h4;
      tick();
    end
    check("a_cnt_after4", a_cnt, 32'd4);
    check("a_pc_after4", a_pc, 32'h10);

    // Stall holds pc and freezes the counter.
    a_stall = 1'b1;
    repeat (3) tick();
    check("a_stall_pc", a_pc, 32'h10);
    check("a_stall_cnt", a_cnt, 32'd4);
    a_stall = 1'b0;
    exp_a_q.push_back(32'h10);
    tick();
    a_fr = 1'b0;
    check("a_unstall_pc", a_pc, 32'h14);
    check("a_unstall_cnt", a_cnt, 32'd5);

    // Redirect flushes through a stall and does not count.
    a_stall = 1'b1; a_rv = 1'b1; a_rt = 32'h200;
    tick();
    check("a_redir_stall_pc", a_pc, 32'h200);
    check("a_redir_stall_cnt", a_cnt, 32'd5);

    // Accept and redirect together: old pc issued and counted, target loaded.
    a_stall = 1'b0; a_fr = 1'b1; a_rt = 32'h300;
    exp_a_q.push_back(32'h200);
    tick();
    a_fr = 1'b0;
    check("a_redir_accept_pc", a_pc, 32'h300);
    check("a_redir_accept_cnt", a_cnt, 32'd6);

    // Trap beats redirect and has its low bits cleared.
    a_rt = 32'h400; a_tv = 1'b1; a_tvec = 32'h807;
    tick();
    a_tv = 1'b0; a_rv = 1'b0;
    check("a_trap_pc", a_pc, 32'h804);

    // Misaligned redirect: one-cycle pulse, address captured, halt.
    a_rv = 1'b1; a_rt = 32'h102;
    tick();
    check("a_mis_pulse", a_mis, 1'b1);
    check("a_mis_addr", a_maddr, 32'h102);
    check("a_mis_pc", a_pc, 32'h804);
    check("a_mis_pv", a_pv, 1'b0);
    a_rt = 32'h500; a_fr = 1'b1;
    tick();
    check("a_mis_pulse_end", a_mis, 1'b0);
    check("a_halt_ignore_pc", a_pc, 32'h804);
    check("a_halt_pv", a_pv, 1'b0);
    check("a_halt_maddr", a_maddr, 32'h102);
    check("a_halt_cnt", a_cnt, 32'd6);
    a_fr = 1'b0; a_rv = 1'b0; a_tv = 1'b1; a_tvec = 32'h80;
    tick();
    a_tv = 1'b0;
    check("a_halt_trap_pc", a_pc, 32'h80);
    check("a_halt_trap_pv", a_pv, 1'b1);

    // Wrap at the top of the address space.
    a_tv = 1'b1; a_tvec = 32'hFFFF_FFFC;
    tick();
    a_tv = 1'b0;
    check("a_top_pc", a_pc, 32'hFFFF_FFFC);
    check("a_top_ppi", a_ppi, 32'h0);
    a_fr = 1'b1;
    exp_a_q.push_back(32'hFFFF_FFFC);
    tick();
    a_fr = 1'b0;
    check("a_wrap_pc", a_pc, 32'h0);
    check("a_wrap_ppi", a_ppi, 32'h4);
    check("a_wrap_cnt", a_cnt, 32'd7);

    // Mid-cycle reset with a misaligned pulse pending.
    a_tv = 1'b1; a_tvec = 32'h40;
    tick();
    a_tv = 1'b0; a_rv = 1'b1; a_rt = 32'h41;
    tick();
    a_rv = 1'b0;
    check("a_pre_rst_mis", a_mis, 1'b1);
    #2 a_reset = 1'b1;
    #1;
    check("a_async_pc", a_pc, 32'h0);
    check("a_async_pv", a_pv, 1'b0);
    check("a_async_mis", a_mis, 1'b0);
    check("a_async_maddr", a_maddr, 32'h0);
    check("a_async_cnt", a_cnt, 32'h0);

    // ---------------- Instance B ----------------
    tick();
    check("b_rst_pc", b_pc, 32'h100);
    check("b_rst_cnt", b_cnt, 4'd0);
    b_reset = 1'b0;
    b_fr    = 1'b1;
    tick();
    exp_pc = 32'h100;
    repeat (17) begin
      exp_b_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'h2;
      tick();
    end
    b_fr = 1'b0;
    check("b_pc_after17", b_pc, 32'h122);
    check("b_ppi_after17", b_ppi, 32'h124);
    check("b_cnt_wrap", b_cnt, 4'd1);

    // 2-byte aligned target is accepted; odd target is not.
    b_rv = 1'b1; b_rt = 32'h102;
    tick();
    check("b_redir_pc", b_pc, 32'h102);
    check("b_redir_mis", b_mis, 1'b0);
    b_rt = 32'h103;
    tick();
    b_rv = 1'b0;
    check("b_mis_pulse", b_mis, 1'b1);
    check("b_mis_addr", b_maddr, 32'h103);
    check("b_mis_pv", b_pv, 1'b0);
    b_tv = 1'b1; b_tvec = 32'h207;
    tick();
    b_tv = 1'b0;
    check("b_trap_pc", b_pc, 32'h206);
    check("b_trap_pv", b_pv, 1'b1);

    #2 b_reset = 1'b1;
    #1;
    check("b_async_pc", b_pc, 32'h100);
    check("b_async_pv", b_pv, 1'b0);

    tick();
    check("a_queue_drained", 64'(exp_a_q.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
